// File: rtl/aes_iter_ctrl.sv
// aes_iter_ctrl - iterative AES-128 encryption controller.
//
// One AddRoundKey/SubBytes/ShiftRows/MixColumns datapath is reused for every
// round. A round counter and a three-state FSM (IDLE/RUN/HOLD) sequence it,
// round keys are fetched by index from an external, combinational key store,
// and the block is wrapped in valid/ready handshakes on both sides.
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. A producer holds valid and data stable until that
// edge, and ready never depends combinationally on the opposite valid.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   plaintext offered
//   in_ready   controller can accept plaintext (IDLE only)
//   in_data    plaintext block
//   rk_idx     round-key index requested this cycle (0..NR)
//   rk_data    round key for rk_idx, valid in the same cycle
//   out_valid  ciphertext available (HOLD)
//   out_ready  consumer accepts ciphertext
//   out_data   ciphertext block (the state register)
//   flush      synchronous abort, highest priority
//   busy       high in RUN or HOLD
//
// Byte order: byte 0 of the AES state is bits [127:120]; byte 4*c+r is
// row r of column c.

module aes_iter_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    input  logic         flush,
    output logic         busy
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fsm_t;

    fsm_t         fsm;
    fsm_t         fsm_nxt;
    logic [127:0] st;
    logic [3:0]   rnd;
    logic [127:0] round_out;

    // ---------------------------------------------------------------------
    // GF(2^8) helpers
    // ---------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // S-box computed rather than tabulated: multiplicative inverse as
    // x^254 (= x^2 * x^4 * ... * x^128, which also maps 0 to 0), followed by
    // the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                   ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    // ---------------------------------------------------------------------
    // Round transforms
    // ---------------------------------------------------------------------
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        end
        return r;
    endfunction

    // Row r of column c takes the byte from column (c+r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127-8*(4*c+w) -: 8] = s[127-8*(4*(((c+w)%4))+w) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    // Shared round datapath; the final round skips MixColumns.
    always_comb begin
        logic [127:0] sr;
        sr = shift_rows(sub_bytes(st));
        if (rnd == LAST_RND) begin
            round_out = sr ^ rk_data;
        end else begin
            round_out = mix_columns(sr) ^ rk_data;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    // FSM: next state (flush overrides every transition)
    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (in_valid) fsm_nxt = RUN;
            RUN:     if (rnd == LAST_RND) fsm_nxt = HOLD;
            HOLD:    if (out_ready) fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
        if (flush) fsm_nxt = IDLE;
    end

    // FSM: outputs, decoded from the state register only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        rk_idx    = 4'd0;
        case (fsm)
            IDLE: in_ready = 1'b1;
            RUN: begin
                busy   = 1'b1;
                rk_idx = rnd;
            end
            HOLD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign out_data = st;

    // ---------------------------------------------------------------------
    // State and round counter. flush clears the counter but leaves st as is.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st  <= '0;
            rnd <= 4'd0;
        end else if (flush) begin
            rnd <= 4'd0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        st  <= in_data ^ rk_data;
                        rnd <= 4'd1;
                    end
                end
                RUN: begin
                    st <= round_out;
                    if (rnd != LAST_RND) rnd <= rnd + 4'd1;
                end
                HOLD: begin
                    if (out_ready) rnd <= 4'd0;
                end
                default: rnd <= 4'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Testbench for aes_iter_ctrl: FIPS-197 vectors through a bench-side key
// store, latency and round-key index sequence, backpressure, back-to-back
// blocks, ignored input during RUN, flush and asynchronous reset.

module tb_aes_iter_ctrl;

    localparam int NR = 10;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT signals
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [127:0] in_data   = '0;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         flush     = 1'b0;
    logic         busy;

    aes_iter_ctrl #(.NR(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .busy      (busy)
    );

    // key store
    logic [127:0] rk_mem [0:NR];
    assign rk_data = (rk_idx <= 4'(NR)) ? rk_mem[rk_idx] : '0;

    // counters and scoreboard
    int tests = 0;
    int fails = 0;
    logic [127:0] exp_q[$];
    int           acc_cyc[$];
    logic [127:0] cur_ct = '0;
    int           cyc = 0;
    logic [7:0]   sb [0:255];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // S-box generated by walking the multiplicative group with 3 and 1/3.
    function automatic logic [7:0] rl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // monitor: away from the active edge, record accepts and consume outputs
    always @(negedge clk) begin
        cyc++;
        if (!rst && !flush) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_ct);
                acc_cyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", out_data, 128'hx);
                end else begin
                    check("ciphertext", out_data, exp_q.pop_front());
                end
            end
        end
    end

    // driver tasks
    task automatic accept_block(input logic [127:0] pt, input logic [127:0] ct);
        int n;
        in_data  = pt;
        in_valid = 1'b1;
        cur_ct   = ct;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                check("accept_timeout", 128'(n), 128'd0);
                break;
            end
        end
        check("rk_idx_handshake", 128'(rk_idx), 128'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("in_ready_after_out", 128'(in_ready), 128'd1);
    endtask

    task automatic cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [3];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{128'h0,
                    128'h0,
                    128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        build_sbox();
        load_key(vecs[0].key);

        // reset state
        cycles(2);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_rk_idx", 128'(rk_idx), 128'd0);
        rst = 1'b0;
        cycles(1);

        // C.1 with round-key index sequence and exact latency
        accept_block(vecs[0].pt, vecs[0].ct);
        for (int r = 1; r <= NR; r++) begin
            check("rk_idx_run", 128'(rk_idx), 128'(r));
            check("out_valid_low_run", 128'(out_valid), 128'd0);
            @(posedge clk);
            #1;
        end
        check("out_valid_latency", 128'(out_valid), 128'd1);
        check("rk_idx_hold", 128'(rk_idx), 128'd0);
        consume();

        // table-driven vectors
        foreach (vecs[i]) begin
            load_key(vecs[i].key);
            accept_block(vecs[i].pt, vecs[i].ct);
            wait_out(n);
            check("latency_edges", 128'(n), 128'(NR));
            consume();
        end

        // backpressure
        load_key(vecs[0].key);
        accept_block(vecs[0].pt, vecs[0].ct);
        wait_out(n);
        for (int i = 0; i < 20; i++) begin
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_out_data", out_data, vecs[0].ct);
            check("bp_in_ready", 128'(in_ready), 128'd0);
            @(posedge clk);
            #1;
        end
        consume();

        // back-to-back blocks
        begin
            int base;
            base = acc_cyc.size();
            in_data   = vecs[0].pt;
            cur_ct    = vecs[0].ct;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            n = 0;
            while (acc_cyc.size() < base + 2 && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            in_valid = 1'b0;
            n = 0;
            while (exp_q.size() != 0 && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            out_ready = 1'b0;
            if (acc_cyc.size() >= base + 2) begin
                check("b2b_accept_spacing", 128'(acc_cyc[base+1] - acc_cyc[base]), 128'(NR + 2));
            end else begin
                check("b2b_accepts", 128'(acc_cyc.size() - base), 128'd2);
            end
            check("b2b_drained", 128'(exp_q.size()), 128'd0);
        end

        // ignored input during RUN
        accept_block(vecs[0].pt, vecs[0].ct);
        cycles(3);
        in_data  = vecs[1].pt;
        in_valid = 1'b1;
        check("ign_in_ready", 128'(in_ready), 128'd0);
        cycles(1);
        in_valid = 1'b0;
        wait_out(n);
        check("ign_latency", 128'(n), 128'(NR - 4));
        consume();

        // flush at rnd=5
        accept_block(vecs[0].pt, vecs[0].ct);
        cycles(4);
        check("flush_at_rnd5", 128'(rk_idx), 128'd5);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        exp_q.delete();
        check("flush_busy", 128'(busy), 128'd0);
        check("flush_in_ready", 128'(in_ready), 128'd1);
        check("flush_out_valid", 128'(out_valid), 128'd0);
        // flush wins over an accept in IDLE
        in_data  = vecs[1].pt;
        in_valid = 1'b1;
        flush    = 1'b1;
        cycles(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_noaccept_busy", 128'(busy), 128'd0);
        check("flush_noaccept_in_ready", 128'(in_ready), 128'd1);
        cycles(2);
        check("flush_noaccept_idle", 128'(busy), 128'd0);
        accept_block(vecs[0].pt, vecs[0].ct);
        wait_out(n);
        check("post_flush_latency", 128'(n), 128'(NR));
        consume();

        // asynchronous reset mid-RUN, between edges
        accept_block(vecs[0].pt, vecs[0].ct);
        cycles(3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 128'(out_valid), 128'd0);
        check("arst_in_ready", 128'(in_ready), 128'd1);
        check("arst_out_data", out_data, 128'd0);
        check("arst_busy", 128'(busy), 128'd0);
        check("arst_rk_idx", 128'(rk_idx), 128'd0);
        exp_q.delete();
        cycles(2);
        #2;
        rst = 1'b0;
        cycles(1);
        accept_block(vecs[0].pt, vecs[0].ct);
        wait_out(n);
        check("post_rst_latency", 128'(n), 128'(NR));
        consume();

        cycles(2);
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
